pwm_rx: RTL and testbench

- Receive-side decoder for the Farbborg LED matrix drive bus: latch shift register (lsr_clr/lsr_d/lsr_c + 8-bit latch data), plane shift register (psr_c/psr_d) and active-low col_enable.
- Oversamples the bus on its own clock and rebuilds which latch got which byte in which plane.
- Emits one event per latch load and flags protocol violations.
- Used in panel emulation and board self-test, so the transmitter's output can be checked in-system.

---
 rtl/pwm_rx_pkg.sv | 29 ++
 rtl/pwm_rx_sync.sv | 48 ++++
 rtl/pwm_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_pwm_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_rx_pkg.sv
// Shared constants and types for the Farbborg drive-bus receiver.
package pwm_rx_pkg;

   localparam int NUM_LATCH_DEF = 10;
   localparam int PLANES_DEF    = 5;
   localparam int DUTY_W_DEF    = 24;

   // Flops between the pad and the edge-detect flop.
   localparam int SYNC_DEPTH = 2;

   // Event field widths.
   localparam int EV_PLANE_W = 3;
   localparam int EV_LATCH_W = 4;
   localparam int EV_DATA_W  = 8;
   localparam int EV_BIT_W   = 3;

   // Plane code reported when no single plane is active.
   localparam logic [EV_PLANE_W-1:0] PLANE_NONE_DEF = EV_PLANE_W'(PLANES_DEF);

   // Monitored LED selector: plane in the top bits, then latch, then bit.
   typedef struct packed {
      logic [EV_PLANE_W-1:0] plane;
      logic [EV_LATCH_W-1:0] latch;
      logic [EV_BIT_W-1:0]   bit_idx;
   } duty_sel_t;

   localparam int DUTY_SEL_W = $bits(duty_sel_t);

endpackage

// File: rtl/pwm_rx_sync.sv
// Synchroniser for one bus clock plus the data sampled with it. The strobe
// passes SYNC_DEPTH flops and one more for edge detection; the data taps
// pass the same number of flops, so edge_o and data_o refer to the same
// sample of the bus.
module pwm_rx_sync
   import pwm_rx_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              strobe_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              edge_o,
   output logic [DATA_W-1:0] data_o
);

   logic [SYNC_DEPTH:0] strb_q, strb_d;
   logic [DATA_W-1:0]   dsync_q [SYNC_DEPTH];
   logic                edge_q, edge_d;
   logic [DATA_W-1:0]   data_q;

   // Shift in the strobe and flag a rising edge between the last two stages.
   always_comb begin
      strb_d = {strb_q[SYNC_DEPTH-1:0], strobe_i};
      edge_d = strb_q[SYNC_DEPTH-1] & ~strb_q[SYNC_DEPTH];
   end

   // Synchroniser chains, registered edge pulse and its matching data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         strb_q <= '0;
         edge_q <= 1'b0;
         data_q <= '0;
         for (int i = 0; i < SYNC_DEPTH; i++) dsync_q[i] <= '0;
      end else begin
         strb_q     <= strb_d;
         edge_q     <= edge_d;
         data_q     <= dsync_q[SYNC_DEPTH-1];
         dsync_q[0] <= data_i;
         for (int i = 1; i < SYNC_DEPTH; i++) dsync_q[i] <= dsync_q[i-1];
      end
   end

   assign edge_o = edge_q;
   assign data_o = data_q;

endmodule

// File: rtl/pwm_rx.sv
// Receive-side decoder for the Farbborg LED matrix drive bus.
// Rebuilds the latch token and plane shift register from an oversampled
// bus, emits one event per latch load and flags protocol errors.
// Optional LED duty monitor is built when PWM_RX_DUTY_EN is defined.
module pwm_rx
   import pwm_rx_pkg::*;
#(
   parameter int NUM_LATCH = NUM_LATCH_DEF,
   parameter int PLANES    = PLANES_DEF,
   parameter int DUTY_W    = DUTY_W_DEF
) (
   input  logic                  pwm_clk,
   input  logic                  reset,
   input  logic                  lsr_clr_i,
   input  logic                  lsr_d_i,
   input  logic                  lsr_c_i,
   input  logic [EV_DATA_W-1:0]  latch_data_i,
   input  logic                  psr_c_i,
   input  logic                  psr_d_i,
   input  logic                  col_enable_i,
   input  logic                  err_clr,
   output logic                  ev_valid,
   output logic [EV_PLANE_W-1:0] ev_plane,
   output logic [EV_LATCH_W-1:0] ev_latch,
   output logic [EV_DATA_W-1:0]  ev_data,
   output logic [PLANES-1:0]     plane_sr,
   output logic                  frame_strobe,
   output logic                  leds_on,
   output logic                  err_overrun,
   output logic                  err_plane,
   input  logic [DUTY_SEL_W-1:0] duty_sel,
   output logic [DUTY_W-1:0]     duty_count,
   output logic                  duty_valid
);

   localparam int LSR_TAP_W = 2 + EV_DATA_W;
   localparam logic [EV_LATCH_W-1:0] LAST_LATCH  = EV_LATCH_W'(NUM_LATCH - 1);
   localparam logic [EV_PLANE_W-1:0] PLANE_NONE  = EV_PLANE_W'(PLANES);
   localparam logic [PLANES-1:0]     PLANE0_ONLY = PLANES'(1);

   // Index of the single set bit, or PLANE_NONE for zero / several set bits.
   function automatic logic [EV_PLANE_W-1:0] plane_index(input logic [PLANES-1:0] v);
      logic [EV_PLANE_W-1:0] idx;
      idx = PLANE_NONE;
      if ($countones(v) == 1) begin
         for (int i = 0; i < PLANES; i++) begin
            if (v[i]) idx = EV_PLANE_W'(i);
         end
      end
      return idx;
   endfunction

   logic                  lsr_edge, psr_edge;
   logic [LSR_TAP_W-1:0]  lsr_tap;
   logic [0:0]            psr_tap;
   logic                  lsr_clr_n_s, lsr_d_s;
   logic [EV_DATA_W-1:0]  latch_data_s;
   logic [SYNC_DEPTH-1:0] col_sync_q;

   logic [EV_LATCH_W-1:0] tok_q, tok_d;
   logic                  tok_v_q, tok_v_d;
   logic                  ev_valid_q, ev_valid_d;
   logic [EV_LATCH_W-1:0] ev_latch_q, ev_latch_d;
   logic [EV_DATA_W-1:0]  ev_data_q, ev_data_d;
   logic                  ovr_set;

   logic [PLANES-1:0]     plane_sr_q, plane_sr_d;
   logic [EV_PLANE_W-1:0] ev_plane_q, ev_plane_d;
   logic                  frame_q, frame_d;
   logic                  leds_on_q, leds_on_d;
   logic                  perr_set;
   logic                  err_overrun_q, err_overrun_d;
   logic                  err_plane_q, err_plane_d;

   pwm_rx_sync #(.DATA_W(LSR_TAP_W)) u_lsr_sync (
      .clk_i    (pwm_clk),
      .rst_ni   (reset),
      .strobe_i (lsr_c_i),
      .data_i   ({lsr_clr_i, lsr_d_i, latch_data_i}),
      .edge_o   (lsr_edge),
      .data_o   (lsr_tap)
   );

   pwm_rx_sync #(.DATA_W(1)) u_psr_sync (
      .clk_i    (pwm_clk),
      .rst_ni   (reset),
      .strobe_i (psr_c_i),
      .data_i   (psr_d_i),
      .edge_o   (psr_edge),
      .data_o   (psr_tap)
   );

   assign {lsr_clr_n_s, lsr_d_s, latch_data_s} = lsr_tap;

   // Plain synchroniser for the column enable; it has no edge semantics.
   always_ff @(posedge pwm_clk or negedge reset) begin
      if (!reset) col_sync_q <= '0;
      else        col_sync_q <= {col_sync_q[SYNC_DEPTH-2:0], col_enable_i};
   end

   // Latch token tracking and event generation; clear beats a same-cycle edge.
   always_comb begin
      tok_d      = tok_q;
      tok_v_d    = tok_v_q;
      ev_valid_d = 1'b0;
      ev_latch_d = ev_latch_q;
      ev_data_d  = ev_data_q;
      ovr_set    = 1'b0;
      if (!lsr_clr_n_s) begin
         tok_d   = '0;
         tok_v_d = 1'b0;
      end else if (lsr_edge) begin
         if (lsr_d_s) begin
            tok_d      = '0;
            tok_v_d    = 1'b1;
            ev_valid_d = 1'b1;
            ev_latch_d = '0;
            ev_data_d  = latch_data_s;
         end else if (tok_v_q && (tok_q < LAST_LATCH)) begin
            tok_d      = tok_q + EV_LATCH_W'(1);
            ev_valid_d = 1'b1;
            ev_latch_d = tok_q + EV_LATCH_W'(1);
            ev_data_d  = latch_data_s;
         end else begin
            tok_v_d = 1'b0;
            ovr_set = 1'b1;
         end
      end
   end

   // Plane register, its decoded view, and error flags (set beats clear).
   always_comb begin
      plane_sr_d    = psr_edge ? {plane_sr_q[PLANES-2:0], psr_tap[0]} : plane_sr_q;
      ev_plane_d    = plane_index(plane_sr_d);
      frame_d       = psr_edge && (plane_sr_d == PLANE0_ONLY);
      perr_set      = psr_edge && ($countones(plane_sr_d) > 1);
      leds_on_d     = !col_sync_q[SYNC_DEPTH-1] && (ev_plane_d != PLANE_NONE);
      err_overrun_d = ovr_set  ? 1'b1 : (err_clr ? 1'b0 : err_overrun_q);
      err_plane_d   = perr_set ? 1'b1 : (err_clr ? 1'b0 : err_plane_q);
   end

   // State and output registers; ev_plane idles at the no-plane code.
   always_ff @(posedge pwm_clk or negedge reset) begin
      if (!reset) begin
         tok_q         <= '0;
         tok_v_q       <= 1'b0;
         ev_valid_q    <= 1'b0;
         ev_latch_q    <= '0;
         ev_data_q     <= '0;
         plane_sr_q    <= '0;
         ev_plane_q    <= PLANE_NONE;
         frame_q       <= 1'b0;
         leds_on_q     <= 1'b0;
         err_overrun_q <= 1'b0;
         err_plane_q   <= 1'b0;
      end else begin
         tok_q         <= tok_d;
         tok_v_q       <= tok_v_d;
         ev_valid_q    <= ev_valid_d;
         ev_latch_q    <= ev_latch_d;
         ev_data_q     <= ev_data_d;
         plane_sr_q    <= plane_sr_d;
         ev_plane_q    <= ev_plane_d;
         frame_q       <= frame_d;
         leds_on_q     <= leds_on_d;
         err_overrun_q <= err_overrun_d;
         err_plane_q   <= err_plane_d;
      end
   end

   assign ev_valid     = ev_valid_q;
   assign ev_plane     = ev_plane_q;
   assign ev_latch     = ev_latch_q;
   assign ev_data      = ev_data_q;
   assign plane_sr     = plane_sr_q;
   assign frame_strobe = frame_q;
   assign leds_on      = leds_on_q;
   assign err_overrun  = err_overrun_q;
   assign err_plane    = err_plane_q;

`ifdef PWM_RX_DUTY_EN
   duty_sel_t            sel;
   logic [EV_DATA_W-1:0] latch_mem_q [NUM_LATCH];
   logic [DUTY_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [DUTY_W-1:0]    duty_count_q, duty_count_d;
   logic                 duty_valid_q, duty_valid_d;
   logic                 lit, inc, leave;

   assign sel = duty_sel_t'(duty_sel);

   // Count lit cycles of the selected LED; report and restart on plane exit.
   always_comb begin
      lit = 1'b0;
      if (sel.latch <= LAST_LATCH) lit = latch_mem_q[sel.latch][sel.bit_idx];
      inc          = leds_on_q && (ev_plane_q == sel.plane) && lit;
      leave        = (ev_plane_q == sel.plane) && (ev_plane_d != sel.plane);
      cnt_inc      = (inc && (cnt_q != '1)) ? cnt_q + DUTY_W'(1) : cnt_q;
      cnt_d        = cnt_inc;
      duty_count_d = duty_count_q;
      duty_valid_d = 1'b0;
      if (leave) begin
         duty_count_d = cnt_inc;
         duty_valid_d = 1'b1;
         cnt_d        = '0;
      end
   end

   // Mirror of latch contents plus duty counter registers.
   always_ff @(posedge pwm_clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_LATCH; i++) latch_mem_q[i] <= '0;
         cnt_q        <= '0;
         duty_count_q <= '0;
         duty_valid_q <= 1'b0;
      end else begin
         if (ev_valid_d) latch_mem_q[ev_latch_d] <= ev_data_d;
         cnt_q        <= cnt_d;
         duty_count_q <= duty_count_d;
         duty_valid_q <= duty_valid_d;
      end
   end

   assign duty_count = duty_count_q;
   assign duty_valid = duty_valid_q;
`else
   logic unused_duty_sel;
   assign unused_duty_sel = ^duty_sel;
   assign duty_count      = '0;
   assign duty_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_rx.sv
// Bench for pwm_rx: directed bus sequences followed by random bus steps,
// each compared against a token/plane reference model kept here.
module tb_pwm_rx;

   localparam int NUM_LATCH = 10;
   localparam int PLANES    = 5;

   logic        pwm_clk = 1'b0;
   logic        reset;
   logic        lsr_clr_i, lsr_d_i, lsr_c_i;
   logic [7:0]  latch_data_i;
   logic        psr_c_i, psr_d_i, col_enable_i, err_clr;
   logic        ev_valid;
   logic [2:0]  ev_plane;
   logic [3:0]  ev_latch;
   logic [7:0]  ev_data;
   logic [4:0]  plane_sr;
   logic        frame_strobe, leds_on, err_overrun, err_plane;
   logic [9:0]  duty_sel;
   logic [23:0] duty_count;
   logic        duty_valid;

   pwm_rx dut (
      .pwm_clk      (pwm_clk),
      .reset        (reset),
      .lsr_clr_i    (lsr_clr_i),
      .lsr_d_i      (lsr_d_i),
      .lsr_c_i      (lsr_c_i),
      .latch_data_i (latch_data_i),
      .psr_c_i      (psr_c_i),
      .psr_d_i      (psr_d_i),
      .col_enable_i (col_enable_i),
      .err_clr      (err_clr),
      .ev_valid     (ev_valid),
      .ev_plane     (ev_plane),
      .ev_latch     (ev_latch),
      .ev_data      (ev_data),
      .plane_sr     (plane_sr),
      .frame_strobe (frame_strobe),
      .leds_on      (leds_on),
      .err_overrun  (err_overrun),
      .err_plane    (err_plane),
      .duty_sel     (duty_sel),
      .duty_count   (duty_count),
      .duty_valid   (duty_valid)
   );

   always #5 pwm_clk = ~pwm_clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          m_tok    = -1;   // -1: no valid token
   bit          m_ovr    = 1'b0;
   bit          m_perr   = 1'b0;
   bit [4:0]    m_plane  = '0;
   int          g_dv_n;
   logic [23:0] g_dv_cnt;

   function automatic int plane_idx(input bit [4:0] v);
      for (int i = 0; i < PLANES; i++) begin
         if (v == 5'(1 << i)) return i;
      end
      return PLANES;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus bit-time: optional lsr_c and/or psr_c rising edge, then the
   // outputs are watched for 8 cycles and compared with the model.
   task automatic bus_step(input bit do_l, input bit l_d, input logic [7:0] l_data,
                           input bit clr_n, input bit do_p, input bit p_d);
      int          ev_n, ev_at, fr_n;
      logic [3:0]  ev_l;
      logic [7:0]  ev_dt;
      logic [2:0]  ev_pl;
      bit          exp_ev;
      exp_ev = 1'b0;
      if (do_p) begin
         m_plane = {m_plane[3:0], p_d};
         if ($countones(m_plane) > 1) m_perr = 1'b1;
      end
      if (!clr_n) m_tok = -1;
      else if (do_l) begin
         if (l_d) begin
            m_tok = 0; exp_ev = 1'b1;
         end else if (m_tok >= 0 && m_tok + 1 < NUM_LATCH) begin
            m_tok++; exp_ev = 1'b1;
         end else begin
            m_tok = -1; m_ovr = 1'b1;
         end
      end

      @(negedge pwm_clk);
      lsr_d_i = l_d; latch_data_i = l_data; lsr_clr_i = clr_n; psr_d_i = p_d;
      lsr_c_i = do_l; psr_c_i = do_p;
      ev_n = 0; ev_at = -1; fr_n = 0; g_dv_n = 0;
      ev_l = 'x; ev_dt = 'x; ev_pl = 'x;
      for (int i = 0; i < 8; i++) begin
         @(negedge pwm_clk);
         if (i == 3) begin lsr_c_i = 1'b0; psr_c_i = 1'b0; end
         if (ev_valid === 1'b1) begin
            if (ev_n == 0) begin ev_at = i; ev_l = ev_latch; ev_dt = ev_data; ev_pl = ev_plane; end
            ev_n++;
         end
         if (frame_strobe === 1'b1) fr_n++;
         if (duty_valid === 1'b1) begin g_dv_n++; g_dv_cnt = duty_count; end
      end
      lsr_clr_i = 1'b1;
      repeat (3) @(negedge pwm_clk);

      check("ev_count", 32'(ev_n), 32'(exp_ev));
      if (exp_ev) begin
         check("ev_latency", 32'(ev_at), 32'd3);
         check("ev_latch", 32'(ev_l), 32'(m_tok));
         check("ev_data", 32'(ev_dt), 32'(l_data));
         check("ev_plane_at_event", 32'(ev_pl), 32'(plane_idx(m_plane)));
      end
      check("frame_count", 32'(fr_n), 32'(do_p && m_plane == 5'b00001));
      check("plane_sr", 32'(plane_sr), 32'(m_plane));
      check("ev_plane", 32'(ev_plane), 32'(plane_idx(m_plane)));
      check("err_overrun", 32'(err_overrun), 32'(m_ovr));
      check("err_plane", 32'(err_plane), 32'(m_perr));
      check("leds_on", 32'(leds_on), 32'(!col_enable_i && plane_idx(m_plane) != PLANES));
`ifndef PWM_RX_DUTY_EN
      check("duty_valid_count", 32'(g_dv_n), 32'd0);
      check("duty_count", 32'(duty_count), 32'd0);
`endif
   endtask

   task automatic clear_errs();
      @(negedge pwm_clk); err_clr = 1'b1;
      @(negedge pwm_clk); err_clr = 1'b0;
      m_ovr = 1'b0; m_perr = 1'b0;
      @(negedge pwm_clk);
      check("err_overrun_cleared", 32'(err_overrun), 32'd0);
      check("err_plane_cleared", 32'(err_plane), 32'd0);
   endtask

   initial begin
      reset = 1'b0; lsr_clr_i = 1'b1; lsr_d_i = 1'b0; lsr_c_i = 1'b0; latch_data_i = '0;
      psr_c_i = 1'b0; psr_d_i = 1'b0; col_enable_i = 1'b1; err_clr = 1'b0;
      duty_sel = {3'd2, 4'd3, 3'd7};

      // Reset values
      repeat (3) @(negedge pwm_clk);
      check("rst_ev_valid", 32'(ev_valid), 32'd0);
      check("rst_ev_plane", 32'(ev_plane), 32'(PLANES));
      check("rst_ev_latch", 32'(ev_latch), 32'd0);
      check("rst_ev_data", 32'(ev_data), 32'd0);
      check("rst_plane_sr", 32'(plane_sr), 32'd0);
      check("rst_frame", 32'(frame_strobe), 32'd0);
      check("rst_leds_on", 32'(leds_on), 32'd0);
      check("rst_err_overrun", 32'(err_overrun), 32'd0);
      check("rst_err_plane", 32'(err_plane), 32'd0);
      check("rst_duty_count", 32'(duty_count), 32'd0);
      check("rst_duty_valid", 32'(duty_valid), 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge pwm_clk);
      check("post_rst_ev_plane", 32'(ev_plane), 32'(PLANES));

      // Full chain of ten latches, then an overrun edge
      bus_step(1, 1, 8'h11, 1, 0, 0);
      for (int k = 1; k < NUM_LATCH; k++) bus_step(1, 0, 8'(8'h11 + k), 1, 0, 0);
      bus_step(1, 0, 8'h55, 1, 0, 0);
      clear_errs();

      // Plane walk with columns enabled, then one step past the end
      col_enable_i = 1'b0;
      bus_step(0, 0, 8'h00, 1, 1, 1);
      repeat (4) bus_step(0, 0, 8'h00, 1, 1, 0);
      bus_step(0, 0, 8'h00, 1, 1, 0);

      // Two ones in the plane register
      bus_step(0, 0, 8'h00, 1, 1, 1);
      bus_step(0, 0, 8'h00, 1, 1, 1);
      clear_errs();

      // Clear coincident with an edge wins; next edge overruns
      bus_step(1, 1, 8'h21, 1, 0, 0);
      bus_step(1, 0, 8'h22, 1, 0, 0);
      bus_step(1, 0, 8'h33, 0, 0, 0);
      bus_step(1, 0, 8'h44, 1, 0, 0);
      clear_errs();

      // Flush planes, then simultaneous psr and lsr edges
      col_enable_i = 1'b1;
      repeat (5) bus_step(0, 0, 8'h00, 1, 1, 0);
      clear_errs();
      bus_step(1, 1, 8'h5A, 1, 1, 1);

      // Duty monitor: latch 3 bit 7 set, plane 2 held with 200 lit cycles
      bus_step(1, 0, 8'h01, 1, 0, 0);
      bus_step(1, 0, 8'h02, 1, 0, 0);
      bus_step(1, 0, 8'h80, 1, 0, 0);
      bus_step(0, 0, 8'h00, 1, 1, 0);
      bus_step(0, 0, 8'h00, 1, 1, 0);
      repeat (150) @(negedge pwm_clk);
      col_enable_i = 1'b0;
      repeat (200) @(negedge pwm_clk);
      col_enable_i = 1'b1;
      repeat (150) @(negedge pwm_clk);
      bus_step(0, 0, 8'h00, 1, 1, 0);
`ifdef PWM_RX_DUTY_EN
      check("duty_valid_pulses", 32'(g_dv_n), 32'd1);
      check("duty_count_200", 32'(g_dv_cnt), 32'd200);
`else
      check("duty_count_off", 32'(duty_count), 32'd0);
`endif

      // Random bus traffic
      for (int n = 0; n < 100; n++) begin
         col_enable_i = ($urandom_range(0, 3) == 0);
         bus_step($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
                  8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) clear_errs();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
